// File: rtl/spi_master_nch.sv
// Parametrised SPI master: any word width, CPOL/CPHA modes, MSB/LSB order,
// programmable SCK half-period, one-hot active-low selects with optional hold.
module spi_master_nch #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  localparam int SS_IW = $clog2(NUM_SS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [SS_IW-1:0]  ss_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              hold_ss_i,
  input  logic              release_i,
  input  logic              miso_i,
  output logic              sck_o,
  output logic              mosi_o,
  output logic [NUM_SS-1:0] ss_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o
);

  localparam int EW = $clog2(2*DATA_W+1);
  localparam logic [EW-1:0] EDGES     = EW'(2*DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W-1);

  // state | meaning
  // IDLE  | selects high, sck at latched cpol
  // GAP   | selects high for one half-period before a slave change
  // LEAD  | slave selected, sck idle, one half-period
  // XFER  | 2*DATA_W sck edges plus the trailing half-period
  // TRAIL | sck idle, select low, one half-period, then done
  // HOLD  | select held low between words
  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_LEAD, S_XFER, S_TRAIL, S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [EW-1:0]      edge_q, edge_d;
  logic [SS_IW-1:0]   ss_q, ss_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               lsbfe_q, lsbfe_d;
  logic               hold_q, hold_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic               done_q, done_d;

  logic tick, accept, do_edge, odd_edge;

  function automatic logic head_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  assign tick     = (cnt_q == div_q);
  assign accept   = start_i && (state_q == S_IDLE || state_q == S_HOLD);
  assign odd_edge = ~edge_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    edge_d  = edge_q;
    ss_d    = ss_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsbfe_d = lsbfe_q;
    hold_d  = hold_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    do_edge = 1'b0;

    case (state_q)
      S_IDLE: cnt_d = '0;
      S_HOLD: begin
        cnt_d = '0;
        if (!start_i && release_i) begin
          state_d = S_IDLE;
          mosi_d  = 1'b0;
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d = S_LEAD;
          if (!cpha_q) begin
            mosi_d = head_bit(tx_q, lsbfe_q);
            tx_d   = advance(tx_q, lsbfe_q);
          end
        end
      end
      S_LEAD: begin
        if (tick) begin
          do_edge = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (tick) begin
          if (edge_q != EDGES) do_edge = 1'b1;
          else                 state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (tick) begin
          done_d = 1'b1;
          rx_d   = rx_sh_q;
          if (hold_q) state_d = S_HOLD;
          else begin
            state_d = S_IDLE;
            mosi_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_GAP, S_LEAD, S_XFER, S_TRAIL})
      cnt_d = tick ? '0 : cnt_q + 1'b1;

    if (accept) begin
      ss_d    = ss_sel_i;
      cpol_d  = cpol_i;
      cpha_d  = cpha_i;
      lsbfe_d = lsbfe_i;
      div_d   = div_i;
      hold_d  = hold_ss_i;
      sck_d   = cpol_i;
      cnt_d   = '0;
      edge_d  = '0;
      rx_sh_d = '0;
      tx_d    = tx_data_i;
      // Changing slave from HOLD inserts a deselected gap; the first
      // cpha=0 bit is then loaded when LEAD begins.
      if (state_q == S_HOLD && ss_sel_i != ss_q) begin
        state_d = S_GAP;
        mosi_d  = 1'b0;
      end else begin
        state_d = S_LEAD;
        if (!cpha_i) begin
          mosi_d = head_bit(tx_data_i, lsbfe_i);
          tx_d   = advance(tx_data_i, lsbfe_i);
        end
      end
    end

    if (do_edge) begin
      sck_d  = ~sck_q;
      edge_d = edge_q + 1'b1;
      if (odd_edge ^ cpha_q)
        rx_sh_d = lsbfe_q ? {miso_i, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso_i};
      if (cpha_q ? odd_edge : (!odd_edge && edge_q != LAST_EDGE)) begin
        mosi_d = head_bit(tx_q, lsbfe_q);
        tx_d   = advance(tx_q, lsbfe_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      ss_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsbfe_q <= 1'b0;
      hold_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      ss_q    <= ss_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsbfe_q <= lsbfe_d;
      hold_q  <= hold_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ss_n_o = '1;
    if (state_q inside {S_LEAD, S_XFER, S_TRAIL, S_HOLD}) ss_n_o[ss_q] = 1'b0;
  end

  assign busy_o    = state_q inside {S_GAP, S_LEAD, S_XFER, S_TRAIL};
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_q;

endmodule
